// File: rtl/axi3_pkg.sv
// Shared AXI3 register-slice definitions: channel modes, field widths and
// per-channel payload widths.
package axi3_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int RESP_W  = 2;

  // A zero-width ID is still carried as one (unused) bit.
  function automatic int id_w(input int id_width);
    return (id_width < 1) ? 1 : id_width;
  endfunction

  function automatic int ax_width(input int addr_width, input int id_width);
    return id_w(id_width) + addr_width + LEN_W + SIZE_W + BURST_W + LOCK_W
           + CACHE_W + PROT_W + QOS_W;
  endfunction

  function automatic int w_width(input int n_bytes, input int id_width);
    return id_w(id_width) + 8 * n_bytes + n_bytes + 1;
  endfunction

  function automatic int b_width(input int id_width);
    return id_w(id_width) + RESP_W;
  endfunction

  function automatic int r_width(input int n_bytes, input int id_width);
    return id_w(id_width) + 8 * n_bytes + RESP_W + 1;
  endfunction

endpackage

// File: rtl/axi3_if.sv
// AXI3 bundle with low-power signals; master/slave modports.
interface axi3_if import axi3_pkg::*; #(
  parameter int N_BYTES    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 4
);

  localparam int IW = id_w(ID_WIDTH);
  localparam int DW = 8 * N_BYTES;

  logic [IW-1:0]         AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [LEN_W-1:0]      AWLEN;
  logic [SIZE_W-1:0]     AWSIZE;
  logic [BURST_W-1:0]    AWBURST;
  logic [LOCK_W-1:0]     AWLOCK;
  logic [CACHE_W-1:0]    AWCACHE;
  logic [PROT_W-1:0]     AWPROT;
  logic [QOS_W-1:0]      AWQOS;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [IW-1:0]         WID;
  logic [DW-1:0]         WDATA;
  logic [N_BYTES-1:0]    WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [IW-1:0]         BID;
  logic [RESP_W-1:0]     BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [IW-1:0]         ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [LEN_W-1:0]      ARLEN;
  logic [SIZE_W-1:0]     ARSIZE;
  logic [BURST_W-1:0]    ARBURST;
  logic [LOCK_W-1:0]     ARLOCK;
  logic [CACHE_W-1:0]    ARCACHE;
  logic [PROT_W-1:0]     ARPROT;
  logic [QOS_W-1:0]      ARQOS;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [IW-1:0]         RID;
  logic [DW-1:0]         RDATA;
  logic [RESP_W-1:0]     RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  logic                  CSYSREQ;
  logic                  CSYSACK;
  logic                  CSYSACTIVE;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output CSYSREQ,
    input  CSYSACK, CSYSACTIVE
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  CSYSREQ,
    output CSYSACK, CSYSACTIVE
  );

endinterface

// File: rtl/axi3_slice_chan.sv
// Generic valid/ready register stage: wires, forward register, or 2-entry
// skid buffer with registered in_ready.
module axi3_slice_chan import axi3_pkg::*; #(
  parameter int          WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             idle
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic bypass_unused;
    assign bypass_unused = clk ^ rst;
    assign out_valid     = in_valid;
    assign in_ready      = out_ready;
    assign out_data      = in_data;
    assign idle          = 1'b1;
  end else if (MODE == SLICE_FWD) begin : g_fwd
    logic             full;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !full || out_ready;
    assign out_valid = full;
    assign out_data  = data_q;
    assign idle      = !full;

    always_ff @(posedge clk) begin
      if (rst)                        full <= 1'b0;
      else if (in_valid && in_ready)  full <= 1'b1;
      else if (out_ready)             full <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (in_valid && in_ready) data_q <= in_data;
    end
  end else begin : g_full
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             rdy_q;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign accept    = in_valid && rdy_q;
    assign drain     = out_ready && (state != EMPTY);
    assign in_ready  = rdy_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign idle      = (state == EMPTY);

    always_comb begin
      state_nx = state;
      case (state)
        EMPTY:   if (accept) state_nx = ONE;
        ONE: begin
          if (accept && !drain)      state_nx = TWO;
          else if (!accept && drain) state_nx = EMPTY;
        end
        TWO:     if (drain) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end

    // in_ready is registered from the next state, so it drops the same
    // edge the second entry fills and is held low throughout reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= EMPTY;
        rdy_q <= 1'b0;
      end else begin
        state <= state_nx;
        rdy_q <= (state_nx != TWO);
      end
    end

    // main_q is always the oldest beat; skid_q only fills while main_q stalls.
    always_ff @(posedge clk) begin
      case (state)
        EMPTY: if (accept) main_q <= in_data;
        ONE: begin
          if (accept && drain) main_q <= in_data;
          else if (accept)     skid_q <= in_data;
        end
        TWO:   if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi3_reg_slice.sv
// AXI3 register slice: one configurable stage per channel, low-power
// handshake passed straight through.
module axi3_reg_slice import axi3_pkg::*; #(
  parameter int          N_BYTES    = 4,
  parameter int          ADDR_WIDTH = 12,
  parameter int          ID_WIDTH   = 4,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FULL,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input  logic   ACLK,
  input  logic   ARESET,
  axi3_if.slave  s,
  axi3_if.master m,
  output logic   IDLE
);

  localparam int AXW = ax_width(ADDR_WIDTH, ID_WIDTH);
  localparam int WW  = w_width(N_BYTES, ID_WIDTH);
  localparam int BW  = b_width(ID_WIDTH);
  localparam int RW  = r_width(N_BYTES, ID_WIDTH);

  logic [AXW-1:0] aw_out;
  logic [WW-1:0]  w_out;
  logic [BW-1:0]  b_out;
  logic [AXW-1:0] ar_out;
  logic [RW-1:0]  r_out;
  logic [4:0]     chan_idle;

  axi3_slice_chan #(.WIDTH(AXW), .MODE(AW_MODE)) u_aw (
    .clk(ACLK), .rst(ARESET),
    .in_valid(s.AWVALID), .in_ready(s.AWREADY),
    .in_data({s.AWID, s.AWADDR, s.AWLEN, s.AWSIZE, s.AWBURST, s.AWLOCK, s.AWCACHE, s.AWPROT, s.AWQOS}),
    .out_valid(m.AWVALID), .out_ready(m.AWREADY), .out_data(aw_out),
    .idle(chan_idle[0])
  );
  assign {m.AWID, m.AWADDR, m.AWLEN, m.AWSIZE, m.AWBURST, m.AWLOCK, m.AWCACHE, m.AWPROT, m.AWQOS} = aw_out;

  axi3_slice_chan #(.WIDTH(WW), .MODE(W_MODE)) u_w (
    .clk(ACLK), .rst(ARESET),
    .in_valid(s.WVALID), .in_ready(s.WREADY),
    .in_data({s.WID, s.WDATA, s.WSTRB, s.WLAST}),
    .out_valid(m.WVALID), .out_ready(m.WREADY), .out_data(w_out),
    .idle(chan_idle[1])
  );
  assign {m.WID, m.WDATA, m.WSTRB, m.WLAST} = w_out;

  axi3_slice_chan #(.WIDTH(BW), .MODE(B_MODE)) u_b (
    .clk(ACLK), .rst(ARESET),
    .in_valid(m.BVALID), .in_ready(m.BREADY),
    .in_data({m.BID, m.BRESP}),
    .out_valid(s.BVALID), .out_ready(s.BREADY), .out_data(b_out),
    .idle(chan_idle[2])
  );
  assign {s.BID, s.BRESP} = b_out;

  axi3_slice_chan #(.WIDTH(AXW), .MODE(AR_MODE)) u_ar (
    .clk(ACLK), .rst(ARESET),
    .in_valid(s.ARVALID), .in_ready(s.ARREADY),
    .in_data({s.ARID, s.ARADDR, s.ARLEN, s.ARSIZE, s.ARBURST, s.ARLOCK, s.ARCACHE, s.ARPROT, s.ARQOS}),
    .out_valid(m.ARVALID), .out_ready(m.ARREADY), .out_data(ar_out),
    .idle(chan_idle[3])
  );
  assign {m.ARID, m.ARADDR, m.ARLEN, m.ARSIZE, m.ARBURST, m.ARLOCK, m.ARCACHE, m.ARPROT, m.ARQOS} = ar_out;

  axi3_slice_chan #(.WIDTH(RW), .MODE(R_MODE)) u_r (
    .clk(ACLK), .rst(ARESET),
    .in_valid(m.RVALID), .in_ready(m.RREADY),
    .in_data({m.RID, m.RDATA, m.RRESP, m.RLAST}),
    .out_valid(s.RVALID), .out_ready(s.RREADY), .out_data(r_out),
    .idle(chan_idle[4])
  );
  assign {s.RID, s.RDATA, s.RRESP, s.RLAST} = r_out;

  assign m.CSYSREQ    = s.CSYSREQ;
  assign s.CSYSACK    = m.CSYSACK;
  assign s.CSYSACTIVE = m.CSYSACTIVE;

  assign IDLE = &chan_idle;

endmodule

// File: tb/tb_axi3_reg_slice.sv
// Directed bench for axi3_reg_slice: a 32-bit slice (B bypassed) and a
// 64-bit, zero-ID-width slice with a forward-register R channel.
module tb_axi3_reg_slice;
  import axi3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic idle0, idle1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s0 (), m0 ();
  axi3_if #(.N_BYTES(8), .ADDR_WIDTH(12), .ID_WIDTH(0)) s1 (), m1 ();

  axi3_reg_slice #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4), .B_MODE(SLICE_BYPASS)) u_dut0 (
    .ACLK(clk), .ARESET(rst), .s(s0.slave), .m(m0.master), .IDLE(idle0)
  );

  axi3_reg_slice #(.N_BYTES(8), .ADDR_WIDTH(12), .ID_WIDTH(0), .R_MODE(SLICE_FWD)) u_dut1 (
    .ACLK(clk), .ARESET(rst), .s(s1.slave), .m(m1.master), .IDLE(idle1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_signals();
    {s0.AWID, s0.AWADDR, s0.AWLEN, s0.AWSIZE, s0.AWBURST, s0.AWLOCK, s0.AWCACHE, s0.AWPROT, s0.AWQOS, s0.AWVALID} = '0;
    {s0.ARID, s0.ARADDR, s0.ARLEN, s0.ARSIZE, s0.ARBURST, s0.ARLOCK, s0.ARCACHE, s0.ARPROT, s0.ARQOS, s0.ARVALID} = '0;
    {s0.WID, s0.WDATA, s0.WSTRB, s0.WLAST, s0.WVALID, s0.BREADY, s0.RREADY, s0.CSYSREQ} = '0;
    {m0.AWREADY, m0.WREADY, m0.ARREADY, m0.BID, m0.BRESP, m0.BVALID} = '0;
    {m0.RID, m0.RDATA, m0.RRESP, m0.RLAST, m0.RVALID, m0.CSYSACK, m0.CSYSACTIVE} = '0;
    {s1.AWID, s1.AWADDR, s1.AWLEN, s1.AWSIZE, s1.AWBURST, s1.AWLOCK, s1.AWCACHE, s1.AWPROT, s1.AWQOS, s1.AWVALID} = '0;
    {s1.ARID, s1.ARADDR, s1.ARLEN, s1.ARSIZE, s1.ARBURST, s1.ARLOCK, s1.ARCACHE, s1.ARPROT, s1.ARQOS, s1.ARVALID} = '0;
    {s1.WID, s1.WDATA, s1.WSTRB, s1.WLAST, s1.WVALID, s1.BREADY, s1.RREADY, s1.CSYSREQ} = '0;
    {m1.AWREADY, m1.WREADY, m1.ARREADY, m1.BID, m1.BRESP, m1.BVALID} = '0;
    {m1.RID, m1.RDATA, m1.RRESP, m1.RLAST, m1.RVALID, m1.CSYSACK, m1.CSYSACTIVE} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++; if (m0.AWVALID !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %b expected 0", m0.AWVALID); end
    vectors++; if (m0.WVALID !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b expected 0", m0.WVALID); end
    vectors++; if (m0.ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", m0.ARVALID); end
    vectors++; if (s0.RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", s0.RVALID); end
    vectors++; if (s0.AWREADY !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b expected 0", s0.AWREADY); end
    vectors++; if (s0.WREADY !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b expected 0", s0.WREADY); end
    vectors++; if (idle0 !== 1'b1) begin errors++; $display("FAIL rst_idle0: got %b expected 1", idle0); end
    vectors++; if (s1.RVALID !== 1'b0) begin errors++; $display("FAIL rst_fwd_rvalid: got %b expected 0", s1.RVALID); end
    vectors++; if (idle1 !== 1'b1) begin errors++; $display("FAIL rst_idle1: got %b expected 1", idle1); end
    rst = 1'b0;
    step();
    vectors++; if (s0.AWREADY !== 1'b1) begin errors++; $display("FAIL post_rst_awready: got %b expected 1", s0.AWREADY); end
    vectors++; if (s0.ARREADY !== 1'b1) begin errors++; $display("FAIL post_rst_arready: got %b expected 1", s0.ARREADY); end
    vectors++; if (s1.WREADY !== 1'b1) begin errors++; $display("FAIL post_rst_wready1: got %b expected 1", s1.WREADY); end
  endtask

  task automatic test_aw_back_to_back();
    m0.AWREADY = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        s0.AWVALID = 1'b1;
        s0.AWADDR  = 12'(i);
        s0.AWID    = 4'(i);
        s0.AWLEN   = 4'(7 - i);
      end else begin
        s0.AWVALID = 1'b0;
      end
      #1;
      if (i < 8) begin
        vectors++; if (s0.AWREADY !== 1'b1) begin errors++; $display("FAIL b2b_awready[%0d]: got %b expected 1", i, s0.AWREADY); end
      end
      if (i == 0) begin
        vectors++; if (m0.AWVALID !== 1'b0) begin errors++; $display("FAIL b2b_latency: got %b expected 0", m0.AWVALID); end
      end else begin
        vectors++; if (m0.AWVALID !== 1'b1) begin errors++; $display("FAIL b2b_awvalid[%0d]: got %b expected 1", i, m0.AWVALID); end
        vectors++; if (m0.AWADDR !== 12'(i - 1)) begin errors++; $display("FAIL b2b_awaddr[%0d]: got %h expected %h", i, m0.AWADDR, 12'(i - 1)); end
        vectors++; if (m0.AWID !== 4'(i - 1)) begin errors++; $display("FAIL b2b_awid[%0d]: got %h expected %h", i, m0.AWID, 4'(i - 1)); end
        vectors++; if (m0.AWLEN !== 4'(8 - i)) begin errors++; $display("FAIL b2b_awlen[%0d]: got %h expected %h", i, m0.AWLEN, 4'(8 - i)); end
      end
      if (i == 4) begin
        vectors++; if (idle0 !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", idle0); end
      end
      step();
    end
    vectors++; if (m0.AWVALID !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", m0.AWVALID); end
    vectors++; if (idle0 !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", idle0); end
    m0.AWREADY = 1'b0;
  endtask

  task automatic test_w_stall();
    m0.WREADY = 1'b0;
    s0.WVALID = 1'b1; s0.WDATA = 32'hA5A5A5A5; s0.WID = 4'h1; s0.WSTRB = 4'hF; s0.WLAST = 1'b0;
    #1;
    vectors++; if (s0.WREADY !== 1'b1) begin errors++; $display("FAIL stall_wready1: got %b expected 1", s0.WREADY); end
    step();
    s0.WDATA = 32'h5A5A5A5A; s0.WID = 4'h2;
    #1;
    vectors++; if (s0.WREADY !== 1'b1) begin errors++; $display("FAIL stall_wready2: got %b expected 1", s0.WREADY); end
    vectors++; if (m0.WVALID !== 1'b1) begin errors++; $display("FAIL stall_wvalid: got %b expected 1", m0.WVALID); end
    step();
    s0.WDATA = 32'h12345678; s0.WID = 4'h3; s0.WLAST = 1'b1;
    #1;
    vectors++; if (s0.WREADY !== 1'b0) begin errors++; $display("FAIL stall_full: got %b expected 0", s0.WREADY); end
    vectors++; if (m0.WDATA !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_head: got %h expected a5a5a5a5", m0.WDATA); end
    step();
    vectors++; if (s0.WREADY !== 1'b0) begin errors++; $display("FAIL stall_still_full: got %b expected 0", s0.WREADY); end
    vectors++; if (m0.WDATA !== 32'hA5A5A5A5 || m0.WID !== 4'h1) begin errors++; $display("FAIL stall_stable: got %h/%h expected a5a5a5a5/1", m0.WDATA, m0.WID); end
    m0.WREADY = 1'b1;
    step();
    vectors++; if (m0.WDATA !== 32'h5A5A5A5A || m0.WID !== 4'h2) begin errors++; $display("FAIL stall_second: got %h/%h expected 5a5a5a5a/2", m0.WDATA, m0.WID); end
    vectors++; if (s0.WREADY !== 1'b1) begin errors++; $display("FAIL stall_reopen: got %b expected 1", s0.WREADY); end
    step();
    s0.WVALID = 1'b0;
    #1;
    vectors++; if (m0.WVALID !== 1'b1) begin errors++; $display("FAIL stall_third_valid: got %b expected 1", m0.WVALID); end
    vectors++; if (m0.WDATA !== 32'h12345678 || m0.WLAST !== 1'b1 || m0.WID !== 4'h3) begin errors++; $display("FAIL stall_third: got %h/%b/%h expected 12345678/1/3", m0.WDATA, m0.WLAST, m0.WID); end
    step();
    vectors++; if (m0.WVALID !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b expected 0", m0.WVALID); end
    vectors++; if (idle0 !== 1'b1) begin errors++; $display("FAIL stall_idle: got %b expected 1", idle0); end
    m0.WREADY = 1'b0; s0.WLAST = 1'b0;
  endtask

  task automatic test_b_bypass();
    m0.BVALID = 1'b1; m0.BRESP = 2'b10; m0.BID = 4'h3; s0.BREADY = 1'b0;
    #1;
    vectors++; if (s0.BVALID !== 1'b1) begin errors++; $display("FAIL byp_bvalid: got %b expected 1", s0.BVALID); end
    vectors++; if (s0.BRESP !== 2'b10) begin errors++; $display("FAIL byp_bresp: got %b expected 10", s0.BRESP); end
    vectors++; if (s0.BID !== 4'h3) begin errors++; $display("FAIL byp_bid: got %h expected 3", s0.BID); end
    vectors++; if (m0.BREADY !== 1'b0) begin errors++; $display("FAIL byp_bready0: got %b expected 0", m0.BREADY); end
    vectors++; if (idle0 !== 1'b1) begin errors++; $display("FAIL byp_idle: got %b expected 1", idle0); end
    s0.BREADY = 1'b1;
    #1;
    vectors++; if (m0.BREADY !== 1'b1) begin errors++; $display("FAIL byp_bready1: got %b expected 1", m0.BREADY); end
    s0.CSYSREQ = 1'b1; m0.CSYSACK = 1'b1; m0.CSYSACTIVE = 1'b1;
    #1;
    vectors++; if ({m0.CSYSREQ, s0.CSYSACK, s0.CSYSACTIVE} !== 3'b111) begin errors++; $display("FAIL lp_pass: got %b expected 111", {m0.CSYSREQ, s0.CSYSACK, s0.CSYSACTIVE}); end
    step();
    m0.BVALID = 1'b0;
    #1;
    vectors++; if (s0.BVALID !== 1'b0) begin errors++; $display("FAIL byp_nostate: got %b expected 0", s0.BVALID); end
    s0.BREADY = 1'b0; s0.CSYSREQ = 1'b0; m0.CSYSACK = 1'b0; m0.CSYSACTIVE = 1'b0;
  endtask

  task automatic test_r_fwd();
    int src = 0;
    int snk = 0;
    int cyc = 0;
    while (snk < 16 && cyc < 100) begin
      s1.RREADY = (cyc % 2 == 0);
      m1.RVALID = (src < 16);
      m1.RDATA  = 64'(src);
      m1.RID    = 1'(src);
      m1.RLAST  = (src == 15);
      #1;
      if (s1.RVALID && s1.RREADY) begin
        vectors++; if (s1.RDATA !== 64'(snk)) begin errors++; $display("FAIL fwd_rdata[%0d]: got %h expected %h", snk, s1.RDATA, 64'(snk)); end
        vectors++; if (s1.RLAST !== (snk == 15)) begin errors++; $display("FAIL fwd_rlast[%0d]: got %b expected %b", snk, s1.RLAST, (snk == 15)); end
        snk++;
      end
      if (m1.RVALID && m1.RREADY) src++;
      step();
      cyc++;
    end
    m1.RVALID = 1'b0; s1.RREADY = 1'b0; m1.RLAST = 1'b0;
    vectors++; if (snk !== 16) begin errors++; $display("FAIL fwd_count: got %0d beats expected 16", snk); end
    vectors++; if (idle1 !== 1'b1) begin errors++; $display("FAIL fwd_idle: got %b expected 1", idle1); end
  endtask

  task automatic test_wide();
    m1.WREADY = 1'b1;
    s1.WVALID = 1'b1; s1.WDATA = 64'hDEADBEEF_01234567; s1.WSTRB = 8'hFF; s1.WLAST = 1'b1; s1.WID = 1'b1;
    #1;
    vectors++; if (s1.WREADY !== 1'b1) begin errors++; $display("FAIL wide_wready: got %b expected 1", s1.WREADY); end
    step();
    s1.WVALID = 1'b0;
    #1;
    vectors++; if (m1.WVALID !== 1'b1) begin errors++; $display("FAIL wide_wvalid: got %b expected 1", m1.WVALID); end
    vectors++; if (m1.WDATA !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL wide_wdata: got %h expected deadbeef01234567", m1.WDATA); end
    vectors++; if ({m1.WSTRB, m1.WLAST, m1.WID} !== 10'h3FF) begin errors++; $display("FAIL wide_ctl: got %h expected 3ff", {m1.WSTRB, m1.WLAST, m1.WID}); end
    step();
    vectors++; if (m1.WVALID !== 1'b0) begin errors++; $display("FAIL wide_empty: got %b expected 0", m1.WVALID); end
    m1.WREADY = 1'b0;
  endtask

  task automatic test_reset_two();
    m0.ARREADY = 1'b0;
    s0.ARVALID = 1'b1; s0.ARADDR = 12'h111; s0.ARID = 4'h4;
    step();
    s0.ARADDR = 12'h222; s0.ARID = 4'h5;
    step();
    s0.ARVALID = 1'b0;
    #1;
    vectors++; if (s0.ARREADY !== 1'b0) begin errors++; $display("FAIL two_arready: got %b expected 0", s0.ARREADY); end
    vectors++; if (m0.ARVALID !== 1'b1 || m0.ARADDR !== 12'h111) begin errors++; $display("FAIL two_head: got %b/%h expected 1/111", m0.ARVALID, m0.ARADDR); end
    vectors++; if (idle0 !== 1'b0) begin errors++; $display("FAIL two_busy: got %b expected 0", idle0); end
    rst = 1'b1;
    step();
    vectors++; if (m0.ARVALID !== 1'b0) begin errors++; $display("FAIL two_rst_valid: got %b expected 0", m0.ARVALID); end
    vectors++; if (idle0 !== 1'b1) begin errors++; $display("FAIL two_rst_idle: got %b expected 1", idle0); end
    vectors++; if (s0.ARREADY !== 1'b0) begin errors++; $display("FAIL two_rst_ready: got %b expected 0", s0.ARREADY); end
    rst = 1'b0; m0.ARREADY = 1'b1;
    step();
    vectors++; if (s0.ARREADY !== 1'b1) begin errors++; $display("FAIL two_release_ready: got %b expected 1", s0.ARREADY); end
    vectors++; if (m0.ARVALID !== 1'b0) begin errors++; $display("FAIL two_stale1: got %b expected 0", m0.ARVALID); end
    step();
    vectors++; if (m0.ARVALID !== 1'b0) begin errors++; $display("FAIL two_stale2: got %b expected 0", m0.ARVALID); end
    m0.ARREADY = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    init_signals();
    test_reset();
    test_aw_back_to_back();
    test_w_stall();
    test_b_bypass();
    test_r_fwd();
    test_wide();
    test_reset_two();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion before 100000");
    $fatal(1);
  end

endmodule

// File: doc/axi3_reg_slice.md
AXI3_REG_SLICE -- requirements
Module: axi3_reg_slice

Interface
REQ-001 Parameter N_BYTES, default 4, data bus width in bytes (WDATA/RDATA = 8*N_BYTES bits).
REQ-002 Parameter ADDR_WIDTH, default 12, AWADDR/ARADDR width.
REQ-003 Parameter ID_WIDTH, default 4, ID width; values below 1 SHALL be carried as 1 bit, with that bit unused.
REQ-004 Parameters AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE, default SLICE_FULL, per-channel mode: SLICE_BYPASS (wires), SLICE_FWD (single forward register), SLICE_FULL (2-entry skid buffer).
REQ-005 ACLK  input  1  the only clock; all state SHALL update on its rising edge.
REQ-006 ARESET  input  1  reset; synchronous, active-high.
REQ-007 s  axi3_if.slave modport  bundle  upstream side, facing the master.
REQ-008 m  axi3_if.master modport  bundle  downstream side, facing the slave.
REQ-009 IDLE  output  1  high when every non-bypass channel stage holds no beat.

Function
REQ-010 Each channel SHALL carry its full payload unmodified: AW/AR {ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS}, W {WID,WDATA,WSTRB,WLAST}, B {BID,BRESP}, R {RID,RDATA,RRESP,RLAST}.
REQ-011 AW, W and AR SHALL flow s->m; B and R SHALL flow m->s; the ready signal of each channel SHALL flow the opposite way.
REQ-012 A beat transfers on a rising edge where VALID and READY are both high; the slice SHALL NOT drop, duplicate or reorder beats.
REQ-013 BYPASS: out_VALID = in_VALID, in_READY = out_READY, payload passes combinationally, no state.
REQ-014 FWD: one register plus valid flag; out_VALID = flag; in_READY = !flag || out_READY (combinational); latency 1 cycle; throughput 1 beat/cycle.
REQ-015 FWD, simultaneous accept and drain: when the flag is set and both handshakes occur, the register SHALL load the new beat and the flag SHALL stay set.
REQ-016 FULL: 2-entry skid buffer with states EMPTY, ONE, TWO; in_READY SHALL be a register output (high in EMPTY/ONE, low in TWO); out_VALID high in ONE/TWO; no combinational path from in to out in either direction.
REQ-017 FULL state transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE stays ONE on accept with drain; TWO->ONE on drain.
REQ-018 FULL ordering: output payload SHALL always be the oldest held beat; latency 1 cycle; sustained throughput 1 beat/cycle with no bubble when the downstream is always ready.
REQ-019 In any non-bypass mode, output VALID SHALL stay high and payload SHALL stay stable until the output handshake occurs.
REQ-020 Low-power signals CSYSREQ, CSYSACK, CSYSACTIVE SHALL pass combinationally between s and m.
REQ-021 IDLE SHALL be registered-state-derived only: the OR of all non-bypass valid flags and states other than EMPTY, inverted.

Reset
REQ-022 While ARESET is high at a rising edge, all valid flags SHALL clear and FULL stages SHALL enter EMPTY.
REQ-023 During reset, all outputs SHALL read: out_VALID=0, FULL in_READY=0, IDLE=1. Payload registers are not reset.
REQ-024 The cycle after ARESET is deasserted, FULL in_READY SHALL read 1.
REQ-025 Reset mid-burst SHALL discard held beats without emitting them.

Structure
REQ-026 A shared package axi3_pkg SHALL hold the slice_mode_e enum (SLICE_BYPASS, SLICE_FWD, SLICE_FULL).
REQ-027 axi3_pkg SHALL hold the per-channel payload-width functions of (N_BYTES, ADDR_WIDTH, ID_WIDTH).
REQ-028 One generic sub-module axi3_slice_chan SHALL be provided with parameters WIDTH and MODE and a valid/ready/data port on each side; it SHALL be instantiated 5 times.

Verification
REQ-029 FULL, out_READY=1, 8 back-to-back AW beats with ADDR 0x000..0x007 -> the same 8 appear on m, consecutive cycles, 1-cycle latency, IDLE=1 after the last beat.
REQ-030 FULL, out_READY=0, push W beats 0xA5A5A5A5 then 0x5A5A5A5A -> s.WREADY=0 after the 2nd accept; after raising READY the beats emerge in order; a 3rd beat is not lost.
REQ-031 FWD, R channel, out_READY toggling 1010..., 16 beats RDATA=index with RLAST on the 16th -> 16 beats in order, RLAST only on the 16th.
REQ-032 BYPASS on B: BVALID=1, BRESP=2'b10, BID=4'h3 -> the same values appear at s in the same cycle; no state is held.
REQ-033 Reset asserted with a FULL stage in TWO -> the next cycle out_VALID=0 and IDLE=1; after release, in_READY=1 and no stale beat appears.
REQ-034 ID_WIDTH=0 and N_BYTES=8 build -> compiles; a 64-bit data transfer passes intact.
